// File: rtl/ftb_update_ctrl_pkg.sv
// FTB update controller: shared types, FSM state encoding and address helpers.
package ftb_update_ctrl_pkg;

   localparam int VADDR_W = 39;

   // One FTB entry as produced by the FTQ at commit.
   typedef struct packed {
      logic        valid;
      logic [3:0]  brOffset;
      logic [11:0] brTarget;
      logic [3:0]  pftAddr;
      logic        carry;
      logic        isCall;
      logic        isRet;
      logic        isJalr;
   } ftbEntry_t;

   // Commit-time BPU update: fetch block start address plus the entry to store.
   typedef struct packed {
      logic [VADDR_W-1:0] startAddr;
      ftbEntry_t          ftb_update;
   } BPupdateInfo_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_RDW,
      ST_CMP,
      ST_WR,
      ST_DONE,
      ST_COOL
   } ftbUpdState_t;

   // Extract 'width' bits of a start address beginning at bit 'lsb' (index or tag field).
   function automatic logic [VADDR_W-1:0] ftb_addr_field(input logic [VADDR_W-1:0] addr,
                                                         input int unsigned        lsb,
                                                         input int unsigned        width);
      ftb_addr_field = (addr >> lsb) & ((VADDR_W'(1) << width) - VADDR_W'(1));
   endfunction

endpackage

// File: rtl/ftb_update_ctrl_victim_sel.sv
// FTB way picker: first tag hit, else first invalid way, else round-robin victim.
module ftb_update_ctrl_victim_sel
   import ftb_update_ctrl_pkg::*;
#(
   parameter int WAYS  = 4,
   parameter int TAG_W = 20,
   localparam int PTR_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]             i_vld,
   input  logic [WAYS-1:0][TAG_W-1:0]  i_tag,
   input  logic [TAG_W-1:0]            i_cmp_tag,
   input  logic [PTR_W-1:0]            i_rr_ptr,
   output logic [WAYS-1:0]             o_way_oh,
   output logic [WAYS-1:0]             o_hit_vec,
   output logic                        o_evict
);

   logic [WAYS-1:0] hit_oh;
   logic [WAYS-1:0] inv_oh;
   logic            hit_found;
   logic            inv_found;

   // Priority-encode hits and invalid ways, fall back to the round-robin pointer.
   always_comb begin
      o_hit_vec = '0;
      hit_oh    = '0;
      inv_oh    = '0;
      hit_found = 1'b0;
      inv_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         o_hit_vec[w] = i_vld[w] && (i_tag[w] == i_cmp_tag);
         if (o_hit_vec[w] && !hit_found) begin
            hit_oh[w] = 1'b1;
            hit_found = 1'b1;
         end
         if (!i_vld[w] && !inv_found) begin
            inv_oh[w] = 1'b1;
            inv_found = 1'b1;
         end
      end
      o_evict = 1'b0;
      if (hit_found) begin
         o_way_oh = hit_oh;
      end else if (inv_found) begin
         o_way_oh = inv_oh;
      end else begin
         o_way_oh = WAYS'(1) << i_rr_ptr;
         o_evict  = 1'b1;
      end
   end

endmodule

// File: rtl/ftb_update_ctrl.sv
// FTB update controller: read-modify-write of one FTB set per FTQ commit update.
module ftb_update_ctrl
   import ftb_update_ctrl_pkg::*;
#(
   parameter int FTB_SETS  = 512,
   parameter int FTB_WAYS  = 4,
   parameter int TAG_WIDTH = 20,
   parameter int IDX_LSB   = 1,
   localparam int IDX_W    = $clog2(FTB_SETS)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                i_update_req,
   input  BPupdateInfo_t                       i_updateInfo,
   output logic                                o_update_finished,
   output logic                                o_busy,
   output logic                                o_sram_rd_req,
   output logic [IDX_W-1:0]                    o_sram_rd_idx,
   input  logic                                i_sram_rd_gnt,
   input  logic [FTB_WAYS-1:0]                 i_sram_rd_vld,
   input  logic [FTB_WAYS-1:0][TAG_WIDTH-1:0]  i_sram_rd_tag,
   output logic                                o_sram_wr_req,
   output logic [IDX_W-1:0]                    o_sram_wr_idx,
   output logic [FTB_WAYS-1:0]                 o_sram_wr_way,
   output logic [TAG_WIDTH-1:0]                o_sram_wr_tag,
   output ftbEntry_t                           o_sram_wr_entry,
   input  logic                                i_sram_wr_gnt
);

   localparam int PTR_W = $clog2(FTB_WAYS);

   ftbUpdState_t                       state_q, state_d;
   ftbEntry_t                          entry_q, entry_d;
   logic [IDX_W-1:0]                   idx_q, idx_d;
   logic [TAG_WIDTH-1:0]               tag_q, tag_d;
   logic [FTB_WAYS-1:0]                rd_vld_q, rd_vld_d;
   logic [FTB_WAYS-1:0][TAG_WIDTH-1:0] rd_tag_q, rd_tag_d;
   logic [FTB_WAYS-1:0]                way_q, way_d;
   logic [PTR_W-1:0]                   rr_q, rr_d;
   logic                               rd_req_q, rd_req_d;
   logic                               wr_req_q, wr_req_d;
   logic                               fin_q, fin_d;

   logic [FTB_WAYS-1:0]                sel_way;
   logic [FTB_WAYS-1:0]                sel_hits;
   logic                               sel_evict;

   ftb_update_ctrl_victim_sel #(
      .WAYS  (FTB_WAYS),
      .TAG_W (TAG_WIDTH)
   ) u_victim_sel (
      .i_vld     (rd_vld_q),
      .i_tag     (rd_tag_q),
      .i_cmp_tag (tag_q),
      .i_rr_ptr  (rr_q),
      .o_way_oh  (sel_way),
      .o_hit_vec (sel_hits),
      .o_evict   (sel_evict)
   );

   // Next-state and registered-output computation for the RMW sequence.
   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      idx_d    = idx_q;
      tag_d    = tag_q;
      rd_vld_d = rd_vld_q;
      rd_tag_d = rd_tag_q;
      way_d    = way_q;
      rr_d     = rr_q;
      rd_req_d = rd_req_q;
      wr_req_d = wr_req_q;
      fin_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (i_update_req) begin
               entry_d  = i_updateInfo.ftb_update;
               idx_d    = IDX_W'(ftb_addr_field(i_updateInfo.startAddr, IDX_LSB, IDX_W));
               tag_d    = TAG_WIDTH'(ftb_addr_field(i_updateInfo.startAddr,
                                                    IDX_LSB + IDX_W, TAG_WIDTH));
               rd_req_d = 1'b1;
               state_d  = ST_RD;
            end
         end
         ST_RD: begin
            if (i_sram_rd_gnt) begin
               rd_req_d = 1'b0;
               state_d  = ST_RDW;
            end
         end
         ST_RDW: begin
            rd_vld_d = i_sram_rd_vld;
            rd_tag_d = i_sram_rd_tag;
            state_d  = ST_CMP;
         end
         ST_CMP: begin
            way_d = sel_way;
            if (sel_evict) begin
               rr_d = rr_q + PTR_W'(1);
            end
            wr_req_d = 1'b1;
            state_d  = ST_WR;
         end
         ST_WR: begin
            if (i_sram_wr_gnt) begin
               wr_req_d = 1'b0;
               fin_d    = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_COOL;
         end
         // The FTQ request is registered and stays high one stale cycle after finished.
         ST_COOL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         entry_q  <= '0;
         idx_q    <= '0;
         tag_q    <= '0;
         rd_vld_q <= '0;
         rd_tag_q <= '0;
         way_q    <= '0;
         rr_q     <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         idx_q    <= idx_d;
         tag_q    <= tag_d;
         rd_vld_q <= rd_vld_d;
         rd_tag_q <= rd_tag_d;
         way_q    <= way_d;
         rr_q     <= rr_d;
         rd_req_q <= rd_req_d;
         wr_req_q <= wr_req_d;
         fin_q    <= fin_d;
      end
   end

   // Protocol sanity: single tag hit per set, exclusive SRAM requests, one-cycle finished.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == ST_CMP) begin
            a_single_hit: assert ($countones(sel_hits) <= 1);
         end
         a_rd_wr_excl: assert (!(rd_req_q && wr_req_q));
         a_fin_pulse:  assert (!(fin_q && fin_d));
      end
   end

   assign o_update_finished = fin_q;
   assign o_busy            = (state_q != ST_IDLE);
   assign o_sram_rd_req     = rd_req_q;
   assign o_sram_rd_idx     = idx_q;
   assign o_sram_wr_req     = wr_req_q;
   assign o_sram_wr_idx     = idx_q;
   assign o_sram_wr_way     = way_q;
   assign o_sram_wr_tag     = tag_q;
   assign o_sram_wr_entry   = entry_q;

endmodule
